// File: rtl/ga25_palette.sv
// GA25 palette: 2048 x 16-bit colour RAM shared between the video
// pixel path and a CPU port, with sync/blank delay matching the RGB.
module ga25_palette #(
    parameter int BLANK_BLACK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        ce_pix,
    input  logic [10:0] color_in,
    input  logic        hblank_in,
    input  logic        vblank_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        mem_cs,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [15:0] addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        busy,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hblank,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync
);

    // Colour RAM and its single shared port
    logic [15:0] ram [0:2047];
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_q;

    // CPU request tracking
    logic        req;
    logic        req_q;
    logic        req_rise;
    logic [10:0] req_idx;
    logic        req_wr;
    logic [15:0] req_din;
    logic        svc;
    logic        cpu_slot;
    logic        cpu_go;

    // Video pipeline
    logic        pix_d;
    logic [15:0] pix_latch;
    logic        d_hb;
    logic        d_vb;
    logic        d_hs;
    logic        d_vs;
    logic        vid_black;

    // Address bits outside the entry index are don't-care, as is bit 15.
    logic        unused_bits;
    assign unused_bits = ^{addr[15:12], addr[0], pix_latch[15]};

    function automatic logic [7:0] x5to8(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    assign req      = mem_cs & (mem_rd | mem_wr);
    assign req_rise = req & ~req_q;

    // CPU owns the RAM only on ce cycles that are not pixel slots, and
    // only once the request has been latched (busy already high).
    assign cpu_slot = ce & ~ce_pix;
    assign cpu_go   = cpu_slot & busy & ~svc & ~reset;

    assign vid_black = (BLANK_BLACK != 0) & (d_hb | d_vb);

    // RAM port mux: video has priority in the pixel slot
    always_comb begin
        ram_addr  = color_in;
        ram_we    = 1'b0;
        ram_wdata = req_din;
        if (!ce_pix && cpu_go) begin
            ram_addr = req_idx;
            ram_we   = req_wr;
        end
    end

    // Synchronous single-port RAM, one clk read latency, never reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_q <= ram[ram_addr];
    end

    // CPU request: edge detect, latch, serve in a CPU slot, complete
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q    <= 1'b0;
            busy     <= 1'b0;
            svc      <= 1'b0;
            req_idx  <= 11'd0;
            req_wr   <= 1'b0;
            req_din  <= 16'd0;
            cpu_dout <= 16'd0;
        end else begin
            req_q <= req;
            if (svc) begin
                if (!req_wr) begin
                    cpu_dout <= ram_q;
                end
                busy <= 1'b0;
                svc  <= 1'b0;
            end else if (cpu_go) begin
                svc <= 1'b1;
            end else if (req_rise && !busy) begin
                busy    <= 1'b1;
                req_idx <= addr[11:1];
                req_wr  <= mem_wr;
                req_din <= cpu_din;
            end
        end
    end

    // Capture the RAM output on the clk after each pixel slot
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_d     <= 1'b0;
            pix_latch <= 16'd0;
        end else begin
            pix_d <= ce_pix;
            if (pix_d) begin
                pix_latch <= ram_q;
            end
        end
    end

    // Delay the timing inputs by one pixel to line up with RGB
    always_ff @(posedge clk) begin
        if (reset) begin
            d_hb <= 1'b0;
            d_vb <= 1'b0;
            d_hs <= 1'b0;
            d_vs <= 1'b0;
        end else if (ce_pix) begin
            d_hb <= hblank_in;
            d_vb <= vblank_in;
            d_hs <= hsync_in;
            d_vs <= vsync_in;
        end
    end

    // Pixel output: expand 5-bit components, black during blanking
    always_ff @(posedge clk) begin
        if (reset) begin
            red    <= 8'd0;
            green  <= 8'd0;
            blue   <= 8'd0;
            hblank <= 1'b1;
            vblank <= 1'b1;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
        end else if (ce_pix) begin
            if (vid_black) begin
                red   <= 8'd0;
                green <= 8'd0;
                blue  <= 8'd0;
            end else begin
                red   <= x5to8(pix_latch[4:0]);
                green <= x5to8(pix_latch[9:5]);
                blue  <= x5to8(pix_latch[14:10]);
            end
            hblank <= d_hb;
            vblank <= d_vb;
            hsync  <= d_hs;
            vsync  <= d_vs;
        end
    end

endmodule

// File: tb/tb_ga25_palette.sv
// Testbench for ga25_palette: scoreboard on the pixel path plus
// directed CPU write/read, contention, held strobe and reset cases.
module tb_ga25_palette;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        ce_pix = 1'b0;
    logic [10:0] color_in = 11'd0;
    logic        hblank_in = 1'b1;
    logic        vblank_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        mem_cs = 1'b0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [15:0] cpu_din = 16'd0;
    logic [15:0] cpu_dout;
    logic        busy;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hblank;
    logic        vblank;
    logic        hsync;
    logic        vsync;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [0:2047];
    logic [27:0] sb [$];
    logic [27:0] last_exp = 28'd0;
    logic        pix_live = 1'b0;
    logic        pix_hold = 1'b0;
    int          pix_n = 0;
    logic [10:0] live_tab [0:4] = '{11'h005, 11'h7FF, 11'h123, 11'h010, 11'h200};

    ga25_palette dut (
        .clk(clk), .reset(reset), .ce(ce), .ce_pix(ce_pix),
        .color_in(color_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr(addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy),
        .red(red), .green(green), .blue(blue),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync)
    );

    initial forever #5 clk = ~clk;

    // ce every 2 clk, ce_pix every other ce
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            ce = (ph % 2) == 0;
            ce_pix = (ph == 0) && !pix_hold;
        end
    end

    function automatic logic [7:0] x5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    function automatic logic [27:0] pix_exp(input logic [10:0] c, input logic hb,
                                            input logic vb, input logic hs,
                                            input logic vs);
        logic [15:0] e;
        logic [23:0] rgb;
        e = model[c];
        if (hb | vb) rgb = 24'd0;
        else rgb = {x5(e[4:0]), x5(e[9:5]), x5(e[14:10])};
        return {rgb, hb, vb, hs, vs};
    endfunction

    // Pixel stimulus: only written entries are shown unblanked
    initial begin
        forever begin
            @(posedge clk);
            if (ce_pix) begin
                @(negedge clk);
                if (pix_live) begin
                    color_in  = live_tab[pix_n % 5];
                    hblank_in = (pix_n % 7) == 6;
                    vblank_in = (pix_n % 13) == 12;
                end else begin
                    color_in  = 11'($urandom_range(0, 2047));
                    hblank_in = 1'b1;
                    vblank_in = 1'($urandom_range(0, 1));
                end
                hsync_in = (pix_n % 5) == 0;
                vsync_in = (pix_n % 11) == 0;
                pix_n++;
            end
        end
    end

    // Scoreboard: push at each ce_pix, compare one pixel later
    initial begin
        logic [10:0] c;
        logic hb, vb, hs, vs;
        logic [27:0] e, o;
        forever begin
            @(posedge clk);
            if (reset) begin
                sb.delete();
            end else if (ce_pix) begin
                c = color_in; hb = hblank_in; vb = vblank_in;
                hs = hsync_in; vs = vsync_in;
                #1;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    o = {red, green, blue, hblank, vblank, hsync, vsync};
                    last_exp = e;
                    checks++;
                    assert (o === e) else begin
                        errors++;
                        $error("FAIL pixel: observed %h expected %h", o, e);
                    end
                end
                sb.push_back(pix_exp(c, hb, vb, hs, vs));
            end
        end
    end

    task automatic cpu_op(input logic wr, input logic [10:0] idx,
                          input logic [15:0] d, output logic [15:0] q,
                          input string tag);
        int n;
        bit seen;
        @(negedge clk);
        mem_cs = 1'b1; mem_wr = wr; mem_rd = !wr;
        addr = {4'h0, idx, 1'b0}; cpu_din = d;
        n = 0; seen = 0;
        while (n < 12) begin
            @(negedge clk);
            n++;
            if (busy) seen = 1;
            else if (seen) break;
        end
        checks++;
        assert (seen && !busy && n <= 8) else begin
            errors++;
            $error("FAIL %s_busy: observed seen=%0d busy=%0d clks=%0d expected pulse ending within 8 clks",
                   tag, seen, busy, n);
        end
        mem_cs = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        if (wr) model[idx] = d;
        q = cpu_dout;
        @(negedge clk);
    endtask

    task automatic chk16(input string tag, input logic [15:0] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    initial begin
        logic [15:0] q;
        logic [15:0] keep;
        logic [52:0] rs;
        int n, rises;
        logic prev;

        repeat (6) @(negedge clk);
        rs = {busy, cpu_dout, red, green, blue, hblank, vblank, hsync, vsync};
        checks++;
        assert (rs === {1'b0, 16'h0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0}) else begin
            errors++;
            $error("FAIL reset_state: observed %h expected %h", rs,
                   {1'b0, 16'h0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        reset = 1'b0;

        cpu_op(1'b1, 11'h123, 16'h7C1F, q, "wr123");
        cpu_op(1'b0, 11'h123, 16'h0000, q, "rd123");
        chk16("rd123", q, 16'h7C1F);

        cpu_op(1'b1, 11'h005, 16'h03E0, q, "wr005");
        cpu_op(1'b1, 11'h7FF, 16'h7FFF, q, "wr7ff");
        cpu_op(1'b1, 11'h010, 16'h1234, q, "wr010");
        cpu_op(1'b1, 11'h200, 16'h4210, q, "wr200");
        cpu_op(1'b0, 11'h7FF, 16'h0000, q, "rd7ff");
        chk16("rd7ff", q, 16'h7FFF);

        pix_live = 1'b1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            cpu_op(1'b1, 11'h300 + 11'(i), 16'h1000 + 16'(i * 16'h111), q, "cwr");
        end
        for (int i = 0; i < 8; i++) begin
            cpu_op(1'b0, 11'h300 + 11'(i), 16'h0, q, "crd");
            chk16("contend_rd", q, 16'h1000 + 16'(i * 16'h111));
        end

        @(negedge clk);
        keep = cpu_dout;
        mem_cs = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
        addr = {4'h0, 11'h123, 1'b0};
        prev = 1'b0; rises = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && !prev) rises++;
            prev = busy;
        end
        mem_cs = 1'b0; mem_rd = 1'b0;
        checks++;
        assert (rises == 1 && !busy) else begin
            errors++;
            $error("FAIL held_strobe: observed %0d busy pulses expected 1", rises);
        end
        chk16("held_rd", cpu_dout, 16'h7C1F);
        @(negedge clk);

        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!ce_pix && n < 10);
        #2 pix_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clk);
            checks++;
            assert ({red, green, blue, hblank, vblank, hsync, vsync} === last_exp) else begin
                errors++;
                $error("FAIL freeze: observed %h expected %h",
                       {red, green, blue, hblank, vblank, hsync, vsync}, last_exp);
            end
        end
        @(posedge clk);
        #2 pix_hold = 1'b0;
        repeat (24) @(negedge clk);

        mem_cs = 1'b1; mem_wr = 1'b1; mem_rd = 1'b0;
        addr = {4'h0, 11'h010, 1'b0}; cpu_din = 16'hDEAD;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 4);
        reset = 1'b1;
        mem_cs = 1'b0; mem_wr = 1'b0;
        checks++;
        assert (n < 4) else begin
            errors++;
            $error("FAIL rst_mid_accept: observed busy=%0d expected 1", busy);
        end
        repeat (6) @(negedge clk);
        checks++;
        assert (busy === 1'b0 && cpu_dout === 16'h0) else begin
            errors++;
            $error("FAIL rst_mid_busy: observed busy=%0d dout=%h expected 0/0000",
                   busy, cpu_dout);
        end
        reset = 1'b0;
        mem_cs = 1'b1; mem_rd = 1'b1;
        addr = {4'h0, 11'h010, 1'b0};
        @(negedge clk);
        checks++;
        assert (busy === 1'b1) else begin
            errors++;
            $error("FAIL post_rst_accept: observed busy=%0d expected 1", busy);
        end
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        mem_cs = 1'b0; mem_rd = 1'b0;
        chk16("rst_mid_keep", cpu_dout, 16'h1234);
        checks++;
        assert (busy === 1'b0) else begin
            errors++;
            $error("FAIL post_rst_done: observed busy=%0d expected 0", busy);
        end

        repeat (40) @(negedge clk);
        cpu_op(1'b0, 11'h005, 16'h0, q, "rd005");
        chk16("rd005", q, 16'h03E0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
